// File: rtl/pdm_decimator.sv
// pdm_decimator
//   Receive end of the 1-bit sigma-delta audio link. A 3rd-order CIC filter
//   decimating by 2**DECIM_LOG2 recovers 16-bit offset-binary PCM
//   (16'h8000 = silence). A peak-hold level meter for the VGA visualiser
//   follows the filter output.
//
//   Parameters
//     DECIM_LOG2   log2 of the decimation ratio R (must be >= 6)
//     DECAY_LOG2   peak meter decays by 1 every 2**DECAY_LOG2 valid samples
//
//   Ports
//     clk48         in   1   system clock, 48 MHz
//     rst_n         in   1   asynchronous active-low reset
//     pdm_in        in   1   bitstream: 1 = +full scale, 0 = -full scale
//     sample        out  16  decimated PCM, offset binary
//     sample_valid  out  1   one-cycle strobe, sample updated on this cycle
//     peak_level    out  8   peak-hold magnitude, 0 = silence, 8'hFF = full
module pdm_decimator #(
  parameter int unsigned DECIM_LOG2 = 10,
  parameter int unsigned DECAY_LOG2 = 4
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        pdm_in,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic [7:0]  peak_level
);

  // CIC bit growth: 1 input bit + 3*log2(R); all arithmetic wraps modulo 2**W.
  localparam int unsigned W = 3 * DECIM_LOG2 + 1;

  logic                  x_q;
  logic [W-1:0]          i1_q, i1_d;
  logic [W-1:0]          i2_q, i2_d;
  logic [W-1:0]          i3_q, i3_d;
  logic [W-1:0]          d1_q, d1_d;
  logic [W-1:0]          d2_q, d2_d;
  logic [W-1:0]          d3_q, d3_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]            warm_q, warm_d;
  logic [DECAY_LOG2-1:0] decay_q, decay_d;
  logic [15:0]           sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic [7:0]            peak_q, peak_d;

  logic                  dec_event;
  logic [W-1:0]          c1, c2, c3;
  logic [15:0]           s;
  logic [7:0]            mag;
  logic                  unused_c3_lsbs;

  assign dec_event = &cnt_q;

  // Comb section, only meaningful on a decimation event.
  assign c1 = i3_q - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;

  // c3 spans 0..2**(W-1); the single top code saturates to 16'hFFFF.
  assign s   = c3[W-1] ? 16'hFFFF : c3[W-2 -: 16];
  assign mag = s[15] ? s[14:7] : ~s[14:7];

  // Comb bits below the 16-bit output resolution are dropped.
  assign unused_c3_lsbs = ^c3[W-18:0];

  always_comb begin
    i1_d     = i1_q + {{(W-1){1'b0}}, x_q};
    i2_d     = i2_q + i1_q;
    i3_d     = i3_q + i2_q;
    cnt_d    = cnt_q + 1'b1;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    warm_d   = warm_q;
    decay_d  = decay_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    peak_d   = peak_q;

    if (dec_event) begin
      d1_d = i3_q;
      d2_d = c1;
      d3_d = c2;
      if (warm_q != 2'd3) begin
        // Comb delays still hold start-up history; suppress output.
        warm_d = warm_q + 2'd1;
      end else begin
        sample_d = s;
        valid_d  = 1'b1;
        if (mag > peak_q) begin
          peak_d  = mag;
          decay_d = '0;
        end else begin
          decay_d = decay_q + 1'b1;
          if ((&decay_q) && (peak_q != 8'h00)) begin
            peak_d = peak_q - 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= 1'b0;
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      cnt_q    <= '0;
      warm_q   <= '0;
      decay_q  <= '0;
      sample_q <= 16'h8000;
      valid_q  <= 1'b0;
      peak_q   <= '0;
    end else begin
      x_q      <= pdm_in;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i3_q     <= i3_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      decay_q  <= decay_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      peak_q   <= peak_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign peak_level   = peak_q;

endmodule
